// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready request driver for a registered 32-bit ALU.
// Optional opcode check (reject opcodes > 3 with rsp_err) under ALU_SEQ_OPCHK_EN.
module alu_op_sequencer #(
   parameter int CAP_LAT = 3,
   parameter int CNT_W   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [6:0]  req_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [6:0]  alu_opcode,
   input  logic [31:0] alu_o,
   input  logic [4:0]  alu_flags,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic [4:0]  rsp_flags,
   output logic        rsp_err,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      alu_a_q, alu_a_d;
   logic [31:0]      alu_b_q, alu_b_d;
   logic [6:0]       alu_op_q, alu_op_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_result_q, rsp_result_d;
   logic [4:0]       rsp_flags_q, rsp_flags_d;
   logic             accept;
   logic             op_bad;

`ifdef ALU_SEQ_OPCHK_EN
   logic rsp_err_q, rsp_err_d;
   assign op_bad  = (req_op > 7'd3);
   assign rsp_err = rsp_err_q;
`else
   assign op_bad  = 1'b0;
   assign rsp_err = 1'b0;
`endif

   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign accept    = req_valid & req_ready;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
`ifdef ALU_SEQ_OPCHK_EN
      rsp_err_d    = rsp_err_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (accept && op_bad) begin
               // illegal op never reaches the ALU; answer immediately
               state_d      = S_RESP;
               rsp_valid_d  = 1'b1;
               rsp_result_d = '0;
               rsp_flags_d  = '0;
`ifdef ALU_SEQ_OPCHK_EN
               rsp_err_d    = 1'b1;
`endif
            end else if (accept) begin
               state_d  = S_WAIT;
               alu_a_d  = req_a;
               alu_b_d  = req_b;
               alu_op_d = req_op;
               cnt_d    = CNT_W'(CAP_LAT - 1);
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d      = S_RESP;
               rsp_valid_d  = 1'b1;
               rsp_result_d = alu_o;
               rsp_flags_d  = alu_flags;
`ifdef ALU_SEQ_OPCHK_EN
               rsp_err_d    = 1'b0;
`endif
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
      end
   end

`ifdef ALU_SEQ_OPCHK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_err_q <= 1'b0;
      end else begin
         rsp_err_q <= rsp_err_d;
      end
   end
`endif

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = alu_op_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed + random checks of alu_op_sequencer against
// a pipelined ALU model (result +1 cycle, flags +2 cycles) and a scoreboard.
module tb_alu_op_sequencer;

   localparam int CAP_LAT = 3;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  fl;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic [6:0]  req_op = '0;
   logic [31:0] alu_a, alu_b;
   logic [6:0]  alu_opcode;
   logic [31:0] alu_o = '0;
   logic [4:0]  alu_flags = '0;
   logic [4:0]  fl_pipe = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_result;
   logic [4:0]  rsp_flags;
   logic        rsp_err;
   logic        busy;

   exp_t        sb[$];
   exp_t        alu_now;
   int          total = 0;
   int          bad = 0;
   int          ncyc = 0;
   int          req_hs_cyc = -1;
   int          rsp_hs_cyc = -1;
   logic [31:0] cur_a = '0;

   alu_op_sequencer #(.CAP_LAT(CAP_LAT), .CNT_W(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_o(alu_o), .alu_flags(alu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // flags = {cOut, negative, zero, parity(even), overflow}
   function automatic exp_t alu_ref(input logic [31:0] a, input logic [31:0] b,
                                    input logic [6:0] op);
      exp_t        e;
      logic [32:0] s;
      logic        c, v;
      logic [31:0] r;
      c = 1'b0;
      v = 1'b0;
      case (op)
         7'd0: r = a | b;
         7'd1: r = a & b;
         7'd2: r = a ^ b;
         7'd3: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0];
            c = s[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         default: r = '0;
      endcase
      e.res = r;
      e.fl  = {c, r[31], (r == 32'd0), ~^r, v};
      e.err = 1'b0;
      return e;
   endfunction

   function automatic logic is_bad(input logic [6:0] op);
`ifdef ALU_SEQ_OPCHK_EN
      return op > 7'd3;
`else
      return 1'b0;
`endif
   endfunction

   function automatic exp_t expect_of(input logic [31:0] a, input logic [31:0] b,
                                      input logic [6:0] op);
      exp_t e;
      if (is_bad(op)) begin
         e.res = '0;
         e.fl  = '0;
         e.err = 1'b1;
      end else begin
         e = alu_ref(a, b, op);
      end
      return e;
   endfunction

   // registered ALU environment: result one cycle after launch, flags one later
   assign alu_now = alu_ref(alu_a, alu_b, alu_opcode);
   always @(posedge clk) begin
      alu_o     <= alu_now.res;
      fl_pipe   <= alu_now.fl;
      alu_flags <= fl_pipe;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      exp_t e;
      if (req_valid && req_ready) begin
         sb.push_back(expect_of(req_a, req_b, req_op));
         req_hs_cyc = ncyc;
         if (!is_bad(req_op)) cur_a = req_a;
      end
      if (rsp_valid && rsp_ready) begin
         rsp_hs_cyc = ncyc;
         if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("sb_result", rsp_result, e.res);
            chk("sb_flags", 32'(rsp_flags), 32'(e.fl));
            chk("sb_err", 32'(rsp_err), 32'(e.err));
         end
      end
      @(posedge clk);
      #1;
      ncyc++;
      if (busy) chk("alu_a_hold", alu_a, cur_a);
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [6:0] op);
      req_a     = a;
      req_b     = b;
      req_op    = op;
      req_valid = 1'b1;
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      cyc();
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat, output int low);
      lat = 0;
      low = int'(!req_ready);
      while (!rsp_valid && lat < 20) begin
         cyc();
         lat++;
         if (!req_ready) low++;
      end
      if (lat >= 20) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [6:0] op,
                         input int hold, output int lat, output int low);
      logic [31:0] r0;
      logic [4:0]  f0;
      rsp_ready = (hold == 0);
      send(a, b, op);
      wait_rsp(lat, low);
      r0 = rsp_result;
      f0 = rsp_flags;
      for (int i = 0; i < hold; i++) begin
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_result", rsp_result, r0);
         chk("hold_flags", 32'(rsp_flags), 32'(f0));
         chk("hold_rdy", 32'(req_ready), 32'd0);
         req_valid = i[0];
         req_a     = ~a;
         req_b     = ~b;
         req_op    = 7'd2;
         cyc();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      cyc();
      chk("idle_after", 32'(req_ready), 32'd1);
   endtask

   initial begin : main
      int          lat, low, n, a1;
      logic [6:0]  op0;
      logic [31:0] ra, rb;

      #1 rst = 1'b1;
      #10;
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_alu_op", 32'(alu_opcode), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_result", rsp_result, 32'd0);
      chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;

      // reset in the middle of WAIT drops the operation
      rsp_ready = 1'b1;
      send(32'h1111_1111, 32'h2222_2222, 7'd3);
      cyc();
      chk("mid_wait_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rstw_busy", 32'(busy), 32'd0);
      chk("rstw_alu_a", alu_a, 32'd0);
      sb.delete();
      cur_a = '0;
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rstw_req_ready", 32'(req_ready), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("rstw_no_rsp", 32'(rsp_valid), 32'd0);
         cyc();
      end

      // reset while a response is pending
      rsp_ready = 1'b0;
      send(32'h0000_00F0, 32'h0000_000F, 7'd0);
      wait_rsp(lat, low);
      chk("pend_valid", 32'(rsp_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rstr_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rstr_rsp_result", rsp_result, 32'd0);
      sb.delete();
      cur_a = '0;
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;

      // ADD 5+3
      run_op(32'd5, 32'd3, 7'd3, 0, lat, low);
      chk("add_lat", 32'(lat), 32'(CAP_LAT));
      chk("add_ready_low", 32'(low), 32'(CAP_LAT + 1));
      chk("add_result", rsp_result, 32'h8);
      chk("add_neg", 32'(rsp_flags[3]), 32'd0);
      chk("add_zero", 32'(rsp_flags[2]), 32'd0);

      // XOR A^A
      run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 7'd2, 0, lat, low);
      chk("xor_result", rsp_result, 32'd0);
      chk("xor_zero", 32'(rsp_flags[2]), 32'd1);
      chk("xor_parity", 32'(rsp_flags[1]), 32'd1);
      chk("xor_neg", 32'(rsp_flags[3]), 32'd0);

      // OR with 5 cycles of backpressure
      run_op(32'h8000_0000, 32'd0, 7'd0, 5, lat, low);
      chk("or_result", rsp_result, 32'h8000_0000);
      chk("or_neg", 32'(rsp_flags[3]), 32'd1);
      chk("or_alu_a", alu_a, 32'h8000_0000);

      // ADD carry/overflow corners
      run_op(32'h7FFF_FFFF, 32'd1, 7'd3, 1, lat, low);
      chk("ovf_flag", 32'(rsp_flags[0]), 32'd1);
      run_op(32'hFFFF_FFFF, 32'd1, 7'd3, 0, lat, low);
      chk("cout_flag", 32'(rsp_flags[4]), 32'd1);
      chk("cout_zero", 32'(rsp_flags[2]), 32'd1);

      // illegal opcode
      op0 = 7'd3;
      run_op(32'h1234_5678, 32'h1, 7'h05, 0, lat, low);
`ifdef ALU_SEQ_OPCHK_EN
      chk("bad_lat", 32'(lat), 32'd0);
      chk("bad_err", 32'(rsp_err), 32'd1);
      chk("bad_result", rsp_result, 32'd0);
      chk("bad_opcode_kept", 32'(alu_opcode), 32'(op0));
`else
      chk("bad_lat", 32'(lat), 32'(CAP_LAT));
      chk("bad_err", 32'(rsp_err), 32'd0);
      chk("bad_opcode_fwd", 32'(alu_opcode), 32'h05);
`endif

      // back-to-back ADDs with req_valid held
      rsp_ready = 1'b1;
      req_a     = 32'd10;
      req_b     = 32'd20;
      req_op    = 7'd3;
      req_valid = 1'b1;
      chk("b2b_ready", 32'(req_ready), 32'd1);
      cyc();
      a1    = req_hs_cyc;
      req_a = 32'd100;
      req_b = 32'd200;
      n     = 0;
      while (req_hs_cyc == a1 && n < 20) begin
         cyc();
         n++;
      end
      req_valid = 1'b0;
      chk("b2b_second_acc", 32'(req_hs_cyc != a1), 32'd1);
      chk("b2b_gap", 32'(req_hs_cyc), 32'(rsp_hs_cyc + 1));
      chk("b2b_interval", 32'(req_hs_cyc - a1), 32'(CAP_LAT + 2));
      wait_rsp(lat, low);
      chk("b2b_result", rsp_result, 32'd300);
      cyc();

      // random legal operations
      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = $urandom;
         run_op(ra, rb, 7'($urandom_range(0, 3)), int'($urandom_range(0, 3)), lat, low);
         chk("rnd_lat", 32'(lat), 32'(CAP_LAT));
         chk("rnd_low", 32'(low), 32'(CAP_LAT + 1));
      end

      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
